// File: rtl/mdu_execute_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package mdu_execute_pkg;

    localparam int XLEN = 32;
    localparam int ITER = XLEN;

    // ALUControlE code the decoder uses to flag an M-extension instruction
    localparam logic [3:0] ALU_CTRL_MDU = 4'b1010;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic [XLEN-1:0] cond_negate(logic [XLEN-1:0] v, logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_execute_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_execute_if;
    import mdu_execute_pkg::*;

    logic            start_e;
    logic [2:0]      op_e;
    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic [4:0]      rd_e;
    logic            flush_e;
    logic            stall_m;
    logic            done_m;
    logic [XLEN-1:0] result_m;
    logic [4:0]      rd_m;

    modport master (
        output start_e, op_e, src_a_e, src_b_e, rd_e, flush_e,
        input  stall_m, done_m, result_m, rd_m
    );

    modport slave (
        input  start_e, op_e, src_a_e, src_b_e, rd_e, flush_e,
        output stall_m, done_m, result_m, rd_m
    );

endinterface

// File: rtl/mdu_execute.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// unsigned magnitudes sharing one 64-bit shift register, sign fixed up at the end.
module mdu_execute #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input logic          clk,
    input logic          rst,
    mdu_execute_if.slave bus
);
    import mdu_execute_pkg::*;

    localparam int CW = $clog2(ITER);

    mdu_state_e        state;
    mdu_state_e        state_next;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mag_b;
    mdu_op_e           op_q;
    logic              neg_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    mdu_op_e         op_in;
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic            is_div_in;
    logic            is_rem_in;
    logic            div_zero;
    logic            div_ovf;
    logic            fast_path;
    logic            neg_in;
    logic            start_go;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic [XLEN-1:0] fast_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_word;

    // Operand decode at start: signedness, magnitudes and the divide fast paths
    always_comb begin
        op_in     = mdu_op_e'(bus.op_e);
        a_signed  = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                    (op_in == MDU_DIV)  || (op_in == MDU_REM);
        b_signed  = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
        sa        = a_signed & bus.src_a_e[XLEN-1];
        sb        = b_signed & bus.src_b_e[XLEN-1];
        mag_a_in  = cond_negate(bus.src_a_e, sa);
        mag_b_in  = cond_negate(bus.src_b_e, sb);
        is_div_in = bus.op_e[2];
        is_rem_in = bus.op_e[2] & bus.op_e[1];
        div_zero  = is_div_in && (bus.src_b_e == '0);
        div_ovf   = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                    (bus.src_a_e == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.src_b_e == '1);
        fast_path = div_zero | div_ovf;
        neg_in    = is_rem_in ? sa : (sa ^ sb);
        if (div_zero)
            fast_result = is_rem_in ? bus.src_a_e : '1;
        else
            fast_result = is_rem_in ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        start_go  = (state == IDLE) && bus.start_e && !bus.flush_e;
    end

    // One radix-2 step of each algorithm plus the final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = acc[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, mag_b};
        if (!rem_diff[XLEN])
            div_next = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            div_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        prod_fix  = neg_q ? (~acc + 1'b1) : acc;
        quo_fix   = cond_negate(acc[XLEN-1:0], neg_q);
        rem_fix   = cond_negate(acc[2*XLEN-1:XLEN], neg_q);
        case (op_q)
            MDU_MUL:                          fix_word = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_word = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_word = quo_fix;
            default:                          fix_word = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state; flush overrides everything, including a start in the same cycle
    always_comb begin
        state_next = state;
        if (bus.flush_e) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start_e) state_next = fast_path ? DONE : CALC;
                CALC: if (count == CW'(ITER-1)) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            acc      <= '0;
            mag_b    <= '0;
            op_q     <= MDU_MUL;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_go) begin
                        op_q  <= op_in;
                        rd_q  <= bus.rd_e;
                        neg_q <= neg_in;
                        mag_b <= mag_b_in;
                        acc   <= {{XLEN{1'b0}}, mag_a_in};
                        count <= '0;
                        if (fast_path) begin
                            result_q <= fast_result;
                            rd_out_q <= bus.rd_e;
                        end
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    acc   <= op_q[2] ? div_next : mul_next;
                end
                FIX: begin
                    if (!bus.flush_e) begin
                        result_q <= fix_word;
                        rd_out_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall is gated by reset so every output reads 0 while reset is held
    assign bus.stall_m  = rst & (((state == IDLE) & bus.start_e & ~bus.flush_e) |
                                 (state == CALC) | (state == FIX));
    assign bus.done_m   = (state == DONE);
    assign bus.result_m = result_q;
    assign bus.rd_m     = rd_out_q;

endmodule

// File: tb/tb_mdu_execute.sv
// Randomised scoreboard bench for mdu_execute against a plain-arithmetic RV32M model.
module tb_mdu_execute;
    import mdu_execute_pkg::*;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t monE;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mdu_execute_if bus();

    mdu_execute #(.XLEN(32), .ITER(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected RV32M result from 64-bit integer arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sbv = $signed(b);
        longint      ua = a;
        longint      ub = b;
        logic [63:0] p;
        logic        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            3'd0: p = ua * ub;
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                p = sa / sbv;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sbv;
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
            end
        endcase
        return p[31:0];
    endfunction

    function automatic bit isFast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 1'b0;
        if (b == 0) return 1'b1;
        return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one instruction and hold start like a stalled EX stage until done
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit holdDone);
        exp_t e;
        bit   seen = 0;
        bit   stallOk = 1;
        @(negedge clk);
        bus.start_e = 1'b1;
        bus.op_e    = op;
        bus.src_a_e = a;
        bus.src_b_e = b;
        bus.rd_e    = rd;
        e.result = refModel(op, a, b);
        e.rd     = rd;
        e.due    = cyc + (isFast(op, a, b) ? 1 : 34);
        sb.push_back(e);
        #1 checkOutput("stall_on_start", {31'b0, bus.stall_m}, 32'd1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done_m) begin
                seen = 1;
                if (bus.stall_m) stallOk = 0;
                break;
            end else if (!bus.stall_m) begin
                stallOk = 0;
            end
        end
        checkOutput("completion", {31'b0, seen}, 32'd1);
        checkOutput("stall_profile", {31'b0, stallOk}, 32'd1);
        if (holdDone) begin
            @(negedge clk);
            checkOutput("no_restart_done", {31'b0, bus.done_m}, 32'd0);
        end
        bus.start_e = 1'b0;
        if (holdDone) begin
            #1 checkOutput("no_restart_stall", {31'b0, bus.stall_m}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.done_m) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got done_m=1 result %h, expected no done (cycle %0d)",
                         bus.result_m, cyc);
            end else begin
                monE = sb.pop_front();
                checkOutput("result", bus.result_m, monE.result);
                checkOutput("rd", {27'b0, bus.rd_m}, {27'b0, monE.rd});
                checkOutput("done_cycle", cyc, monE.due);
            end
        end
    end

    initial begin
        bit stallFlushOk;
        rst         = 1'b0;
        bus.start_e = 1'b0;
        bus.op_e    = 3'd0;
        bus.src_a_e = '0;
        bus.src_b_e = '0;
        bus.rd_e    = '0;
        bus.flush_e = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_result", bus.result_m, 32'h0);
        checkOutput("reset_rd", {27'b0, bus.rd_m}, 32'h0);
        checkOutput("reset_done", {31'b0, bus.done_m}, 32'h0);
        checkOutput("reset_stall", {31'b0, bus.stall_m}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] directed operations");
        applyStimulus(MDU_MUL,    32'd7,          32'hFFFFFFFD, 5'd3,  1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(MDU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd4,  1'b0);
        applyStimulus(MDU_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd5,  1'b0);
        applyStimulus(MDU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  1'b0);
        applyStimulus(MDU_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  1'b0);
        applyStimulus(MDU_DIV,    32'hFFFFFFF9,   32'd2,        5'd8,  1'b0);
        applyStimulus(MDU_REM,    32'hFFFFFFF9,   32'd2,        5'd9,  1'b0);
        applyStimulus(MDU_DIVU,   32'd100,        32'd7,        5'd10, 1'b0);
        applyStimulus(MDU_REMU,   32'd100,        32'd7,        5'd11, 1'b0);
        applyStimulus(MDU_DIVU,   32'd5,          32'd0,        5'd12, 1'b0);
        applyStimulus(MDU_REMU,   32'd5,          32'd0,        5'd13, 1'b0);
        applyStimulus(MDU_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd14, 1'b0);
        applyStimulus(MDU_REM,    32'h80000000,   32'hFFFFFFFF, 5'd15, 1'b0);

        $display("[TB] flush mid-multiply");
        @(negedge clk);
        bus.start_e = 1'b1;
        bus.op_e    = MDU_MUL;
        bus.src_a_e = 32'd123;
        bus.src_b_e = 32'd456;
        bus.rd_e    = 5'd20;
        repeat (10) @(negedge clk);
        bus.flush_e = 1'b1;
        bus.start_e = 1'b0;
        @(negedge clk);
        bus.flush_e = 1'b0;
        checkOutput("flush_stall_drop", {31'b0, bus.stall_m}, 32'd0);
        repeat (40) @(negedge clk);

        $display("[TB] start and flush together");
        bus.start_e = 1'b1;
        bus.flush_e = 1'b1;
        #1 checkOutput("start_flush_stall", {31'b0, bus.stall_m}, 32'd0);
        @(negedge clk);
        bus.start_e = 1'b0;
        bus.flush_e = 1'b0;
        stallFlushOk = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.stall_m) stallFlushOk = 0;
        end
        checkOutput("start_flush_idle", {31'b0, stallFlushOk}, 32'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(MDU_DIVU, 32'd100, 32'd7, 5'd9, 1'b0);
        @(negedge clk);
        bus.start_e = 1'b1;
        bus.op_e    = MDU_MUL;
        bus.src_a_e = 32'd9;
        bus.src_b_e = 32'd9;
        bus.rd_e    = 5'd21;
        repeat (5) @(negedge clk);
        rst         = 1'b0;
        bus.start_e = 1'b0;
        #1;
        checkOutput("async_reset_result", bus.result_m, 32'h0);
        checkOutput("async_reset_rd", {27'b0, bus.rd_m}, 32'h0);
        checkOutput("async_reset_stall", {31'b0, bus.stall_m}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(MDU_MUL, 32'd3, 32'd4, 5'd22, 1'b0);

        $display("[TB] randomised operations");
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rd;
            op = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            rd = 5'($urandom_range(0, 31));
            applyStimulus(op, a, b, rd, 1'b0);
        end

        repeat (40) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
